// File: rtl/chroma_sumsq_if.sv
// Handshake bundle for chroma_sumsq: (Cb, Cr) input channel and 32-bit sum output channel.
interface chroma_sumsq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] cb;
    logic [WIDTH-1:0] cr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      sum;

    // Producer/consumer side (drives pairs, accepts sums)
    modport master (
        output in_valid, cb, cr, out_ready,
        input  in_ready, out_valid, sum
    );

    // Sum-of-squares block side
    modport slave (
        input  in_valid, cb, cr, out_ready,
        output in_ready, out_valid, sum
    );
endinterface

// File: rtl/chroma_sumsq.sv
// chroma_sumsq: serial Cb'^2 + Cr'^2 stage feeding the 32-bit square-root unit.
// Each component magnitude is squared by an LSB-first shift-add multiplier,
// WIDTH cycles per square, and the zero-extended sum is held until taken.
// Build option: define CHROMA_OFFSET_EN for offset-binary inputs centered at
// 2^(WIDTH-1); leave it undefined for two's-complement signed inputs.
module chroma_sumsq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    chroma_sumsq_if.slave        bus,
    output logic                 busy
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQ_B = 2'd1,
        SQ_R = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   bit_cnt, bit_cnt_d;
    logic [PW-1:0]   mcand, mcand_d;
    logic [WIDTH-1:0] mplier, mplier_d;
    logic [PW-1:0]   prod, prod_d;
    logic [WIDTH-1:0] mag_r, mag_r_d;
    logic [PW-1:0]   acc, acc_d;
    logic [31:0]     sum_q, sum_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic [WIDTH-1:0] d_b_c, d_r_c;
    logic [WIDTH-1:0] mag_b_c, mag_r_c;
    logic [PW-1:0]    prod_step_c;
    logic             last_bit_c;

    // Signed difference from the raw sample; offset-binary removal is an MSB flip
`ifdef CHROMA_OFFSET_EN
    assign d_b_c = {~bus.cb[WIDTH-1], bus.cb[WIDTH-2:0]};
    assign d_r_c = {~bus.cr[WIDTH-1], bus.cr[WIDTH-2:0]};
`else
    assign d_b_c = bus.cb;
    assign d_r_c = bus.cr;
`endif

    // WIDTH-bit unsigned magnitude; -2^(WIDTH-1) maps exactly to 2^(WIDTH-1)
    assign mag_b_c = d_b_c[WIDTH-1] ? WIDTH'(~d_b_c + WIDTH'(1)) : d_b_c;
    assign mag_r_c = d_r_c[WIDTH-1] ? WIDTH'(~d_r_c + WIDTH'(1)) : d_r_c;

    // One shift-add step of the serial multiplier
    assign prod_step_c = mplier[0] ? PW'(prod + mcand) : prod;
    assign last_bit_c  = (bit_cnt == CW'(WIDTH - 1));

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state;
        bit_cnt_d   = bit_cnt;
        mcand_d     = mcand;
        mplier_d    = mplier;
        prod_d      = prod;
        mag_r_d     = mag_r;
        acc_d       = acc;
        sum_d       = sum_q;

        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    mcand_d   = PW'(mag_b_c);
                    mplier_d  = mag_b_c;
                    prod_d    = '0;
                    mag_r_d   = mag_r_c;
                    bit_cnt_d = '0;
                    state_d   = SQ_B;
                end
            end
            SQ_B: begin
                prod_d    = prod_step_c;
                mcand_d   = mcand << 1;
                mplier_d  = mplier >> 1;
                bit_cnt_d = bit_cnt + CW'(1);
                if (last_bit_c) begin
                    acc_d     = PW'(acc + prod_step_c);
                    mcand_d   = PW'(mag_r);
                    mplier_d  = mag_r;
                    prod_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = SQ_R;
                end
            end
            SQ_R: begin
                prod_d    = prod_step_c;
                mcand_d   = mcand << 1;
                mplier_d  = mplier >> 1;
                bit_cnt_d = bit_cnt + CW'(1);
                if (last_bit_c) begin
                    acc_d     = PW'(acc + prod_step_c);
                    sum_d     = 32'(PW'(acc + prod_step_c));
                    bit_cnt_d = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            mcand       <= '0;
            mplier      <= '0;
            prod        <= '0;
            mag_r       <= '0;
            acc         <= '0;
            sum_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_d;
            bit_cnt     <= bit_cnt_d;
            mcand       <= mcand_d;
            mplier      <= mplier_d;
            prod        <= prod_d;
            mag_r       <= mag_r_d;
            acc         <= acc_d;
            sum_q       <= sum_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_chroma_sumsq.sv
// Directed self-checking bench for chroma_sumsq (WIDTH=8), both input encodings.
module tb_chroma_sumsq;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned LAT   = 2 * WIDTH;
`ifdef CHROMA_OFFSET_EN
    localparam bit OFFSET = 1'b1;
`else
    localparam bit OFFSET = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    chroma_sumsq_if #(.WIDTH(WIDTH)) bus ();

    chroma_sumsq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Encode a signed difference into the sample format of this build
    function automatic logic [7:0] enc(input int d);
        if (OFFSET) return 8'(d + 128);
        else        return 8'(d);
    endfunction

    // Full transaction with latency, sum and handshake checks
    task automatic do_txn(input int db, input int dr, input logic [31:0] exp, input string name);
        int n;
        bus.cb = enc(db);
        bus.cr = enc(dr);
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL %s accept: in_ready=%b required 1", name, bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (n !== LAT) begin
            errors++; $display("FAIL %s latency: got %0d cycles required %0d", name, n, LAT);
        end
        checks++;
        if (bus.sum !== exp) begin
            errors++; $display("FAIL %s sum: got %0d required %0d", name, bus.sum, exp);
        end
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL %s done_flags: busy=%b in_ready=%b required 1 0", name, busy, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL %s release: out_valid=%b in_ready=%b required 0 1", name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.cb = '0; bus.cr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.sum !== 32'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b sum=%0d busy=%b required 0 0 0 0",
                     bus.in_ready, bus.out_valid, bus.sum, busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_release: in_ready=%b required 1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        do_txn(0, 0, 32'd0, "zero");
        do_txn(3, 4, 32'd25, "three_four");
        do_txn(-128, -128, 32'd32768, "most_negative");
        do_txn(-10, -128, 32'd16484, "mixed_neg");
    endtask

    task automatic test_backpressure();
        int n;
        bus.cb = enc(3); bus.cr = enc(4); bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin @(posedge clk); #1; n++; end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.sum !== 32'd25) begin
            errors++; $display("FAIL bp_first: out_valid=%b sum=%0d required 1 25", bus.out_valid, bus.sum);
        end
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = i[0];
            bus.cb = enc(i - 50);
            bus.cr = enc(7 * i);
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.sum !== 32'd25 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: out_valid=%b sum=%0d in_ready=%b required 1 25 0",
                         i, bus.out_valid, bus.sum, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.sum !== 32'd25 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_after: sum=%0d busy=%b required 25 0", bus.sum, busy);
        end
    endtask

    task automatic test_reset_abort();
        bus.cb = enc(100); bus.cr = enc(-90); bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.sum !== 32'd0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort: out_valid=%b sum=%0d busy=%b in_ready=%b required 0 0 0 0",
                     bus.out_valid, bus.sum, busy, bus.in_ready);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_txn(3, 0, 32'd9, "post_abort");
    endtask

    task automatic test_back_to_back();
        int          db [4] = '{1, -5, -128, 127};
        int          dr [4] = '{2, 7, -128, -1};
        logic [31:0] ex [4] = '{32'd5, 32'd74, 32'd32768, 32'd16130};
        int  idx = 0, nout = 0, last = 0;
        bit  hs, tx;
        bus.cb = enc(db[0]); bus.cr = enc(dr[0]);
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && nout < 4; cyc++) begin
            hs = bus.in_valid && bus.in_ready;
            tx = bus.out_valid && bus.out_ready;
            if (tx) begin
                checks++;
                if (bus.sum !== ex[nout]) begin
                    errors++; $display("FAIL b2b_sum %0d: got %0d required %0d", nout, bus.sum, ex[nout]);
                end
                if (nout > 0) begin
                    checks++;
                    if (cyc - last !== 18) begin
                        errors++; $display("FAIL b2b_spacing %0d: got %0d cycles required 18", nout, cyc - last);
                    end
                end
                last = cyc;
                nout++;
            end
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                if (idx < 4) begin bus.cb = enc(db[idx]); bus.cr = enc(dr[idx]); end
                else bus.in_valid = 1'b0;
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (nout !== 4) begin
            errors++; $display("FAIL b2b_count: got %0d results required 4", nout);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global bound so the run always terminates
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
